uart_tx_arbiter: RTL and testbench

//  Shares one UART transmit line between NUM_REQ requesters. Round-robin arbitration picks one

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit line between NUM_REQ requesters. Picks one requester per frame in
// round-robin order, latches its byte and sends it as 8N1 (start, DATA_WIDTH data bits LSB
// first, stop). Each bit lasts exactly one enb_tx baud tick.
//
// Ports
//   clock       system clock, all logic on posedge
//   reset       synchronous, active-high; aborts any frame in progress
//   enb_tx      one-cycle baud tick, one tick per bit period
//   req         req[i]: requester i has a byte ready, held until grant[i]
//   data_in     byte i at data_in[i*DATA_WIDTH +: DATA_WIDTH]
//   grant       one-hot, one-cycle pulse: byte i accepted
//   tx          serial line, idle high
//   busy        high from the grant cycle until the frame ends
//   active_id   index of the requester being served, valid while busy
//   frame_done  one-cycle pulse when the stop bit completes
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_W       = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enb_tx,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx,
  output logic                          busy,
  output logic [ID_W-1:0]               active_id,
  output logic                          frame_done
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [ID_W-1:0]       rr_ptr_q;

  // Round-robin winner search: offset k from rr_ptr_q, first set request wins.
  logic                  win_valid;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       win_next;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DATA_WIDTH-1:0] win_data;

  always_comb begin
    int unsigned pos;
    win_valid  = 1'b0;
    win_id     = '0;
    win_next   = '0;
    win_onehot = '0;
    win_data   = '0;
    pos        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!win_valid && req[i] && (i == pos)) begin
          win_valid     = 1'b1;
          win_id        = ID_W'(i);
          win_onehot[i] = 1'b1;
          win_data      = data_in[i*DATA_WIDTH +: DATA_WIDTH];
          win_next      = (i == NUM_REQ - 1) ? '0 : ID_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      tx         <= 1'b1;
      grant      <= '0;
      busy       <= 1'b0;
      active_id  <= '0;
      frame_done <= 1'b0;
    end else begin
      grant      <= '0;
      frame_done <= 1'b0;
      case (state_q)
        // enb_tx is deliberately ignored here so the start bit is aligned to a later tick.
        StIdle: begin
          tx <= 1'b1;
          if (win_valid) begin
            shift_q   <= win_data;
            bit_cnt_q <= '0;
            grant     <= win_onehot;
            active_id <= win_id;
            busy      <= 1'b1;
            rr_ptr_q  <= win_next;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (enb_tx) begin
            tx      <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (enb_tx) begin
            tx        <= shift_q[0];
            shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_q <= CntW'(1);
            state_q   <= StData;
          end
        end
        // bit_cnt_q counts data bits already on the line; the last one is followed by stop.
        StData: begin
          if (enb_tx) begin
            if (bit_cnt_q == CntW'(DATA_WIDTH)) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              tx        <= shift_q[0];
              shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
        end
        StStop: begin
          if (enb_tx) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: stimulus pushes expected grants/bytes into a scoreboard queue,
// a negedge monitor pops an entry on every grant and checks the serial frame tick by tick.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enb_tx = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  data [4];
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic        tx;
  logic        busy;
  logic [1:0]  active_id;
  logic        frame_done;

  assign data_in = {data[3], data[2], data[1], data[0]};

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .ID_W      (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enb_tx    (enb_tx),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .tx        (tx),
    .busy      (busy),
    .active_id (active_id),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] onehot;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  int   frames_done = 0;
  int   grants_seen = 0;
  int   tick_idx = 0;
  int   tick_cnt = 0;
  bit   mon_active = 1'b0;
  bit   tick_on = 1'b0;
  bit   force_tick = 1'b0;
  logic last_tx = 1'b1;
  logic tick_at_edge = 1'b0;
  logic reset_at_edge = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.onehot = 4'(1 << id);
    e.id     = 2'(id);
    e.data   = d;
    sb.push_back(e);
  endtask

  // Baud tick: one pulse every 16 clocks while tick_on, or a forced pulse on demand.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (tick_on) tick_cnt = (tick_cnt + 1) % 16;
      else tick_cnt = 0;
      enb_tx = (tick_on && tick_cnt == 15) || force_tick;
    end
  end

  always @(posedge clock) begin
    tick_at_edge  <= enb_tx;
    reset_at_edge <= reset;
  end

  always @(negedge clock) begin
    logic [9:0] bits;
    logic       exp_bit;
    if (reset_at_edge) begin
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_active_id", 32'(active_id), 32'd0);
      mon_active = 1'b0;
    end else if (grant != 4'b0) begin
      check("grant_during_frame", 32'(mon_active), 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_grant: got %b expected none at %0t", grant, $time);
      end else begin
        cur = sb.pop_front();
        check("grant", 32'(grant), 32'(cur.onehot));
        check("active_id", 32'(active_id), 32'(cur.id));
        check("busy_at_grant", 32'(busy), 32'd1);
        check("tx_at_grant", 32'(tx), 32'd1);
      end
      mon_active = 1'b1;
      tick_idx   = 0;
      last_tx    = 1'b1;
      grants_seen++;
    end else if (mon_active) begin
      if (tick_at_edge) begin
        if (tick_idx < 10) begin
          bits    = {1'b1, cur.data, 1'b0};
          exp_bit = bits[tick_idx[3:0]];
          check("tx_bit", 32'(tx), 32'(exp_bit));
          check("frame_done_early", 32'(frame_done), 32'd0);
          last_tx = tx;
          tick_idx++;
        end else begin
          check("frame_done", 32'(frame_done), 32'd1);
          check("busy_at_end", 32'(busy), 32'd0);
          check("tx_idle_at_end", 32'(tx), 32'd1);
          mon_active = 1'b0;
          frames_done++;
        end
      end else begin
        check("tx_hold", 32'(tx), 32'(last_tx));
        check("active_id_hold", 32'(active_id), 32'(cur.id));
        check("busy_hold", 32'(busy), 32'd1);
        check("frame_done_hold", 32'(frame_done), 32'd0);
      end
    end else begin
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_frame_done", 32'(frame_done), 32'd0);
    end
  end

  task automatic wait_grants(input int target, input string name);
    int n = 0;
    while (grants_seen < target && n < 2000) begin
      @(negedge clock);
      #2;
      n++;
    end
    n_vec++;
    if (grants_seen < target) begin
      n_err++;
      $display("FAIL %s: timeout, got %0d grants expected %0d", name, grants_seen, target);
    end
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames_done < target && n < 2000) begin
      @(negedge clock);
      #2;
      n++;
    end
    n_vec++;
    if (frames_done < target) begin
      n_err++;
      $display("FAIL %s: timeout, got %0d frames expected %0d", name, frames_done, target);
    end
  endtask

  task automatic wait_tick_idx(input int target, input string name);
    int n = 0;
    while (!(mon_active && tick_idx >= target) && n < 2000) begin
      @(negedge clock);
      #2;
      n++;
    end
    n_vec++;
    if (!(mon_active && tick_idx >= target)) begin
      n_err++;
      $display("FAIL %s: timeout, got tick %0d expected %0d", name, tick_idx, target);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int g0;
    int f0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    repeat (3) @(negedge clock);
    reset   = 1'b0;
    tick_on = 1'b1;

    // 1: single frame from req0.
    data[0] = 8'hA5;
    push(0, 8'hA5);
    req = 4'b0001;
    wait_grants(1, "t1_grant");
    req = 4'b0000;
    wait_frames(1, "t1_frame");

    // 2: req0 and req2 held, alternating grants from a fresh pointer.
    pulse_reset();
    data[2] = 8'hC3;
    push(0, 8'hA5);
    push(2, 8'hC3);
    push(0, 8'hA5);
    push(2, 8'hC3);
    g0  = grants_seen;
    f0  = frames_done;
    req = 4'b0101;
    wait_grants(g0 + 4, "t2_grants");
    req = 4'b0000;
    wait_frames(f0 + 4, "t2_frames");

    // 3: req3 raised mid-frame waits for the end of the current frame.
    data[3] = 8'h96;
    push(0, 8'hA5);
    push(3, 8'h96);
    g0  = grants_seen;
    f0  = frames_done;
    req = 4'b0001;
    wait_grants(g0 + 1, "t3_grant0");
    req = 4'b0000;
    wait_tick_idx(3, "t3_mid");
    req[3] = 1'b1;
    wait_grants(g0 + 2, "t3_grant3");
    req = 4'b0000;
    wait_frames(f0 + 2, "t3_frames");

    // 4: reset inside the data phase aborts the frame and restarts arbitration at req0.
    data[1] = 8'h6B;
    push(1, 8'h6B);
    g0  = grants_seen;
    req = 4'b0010;
    wait_grants(g0 + 1, "t4_grant1");
    req = 4'b0000;
    wait_tick_idx(5, "t4_data");
    pulse_reset();
    data[1] = 8'h81;
    data[3] = 8'h7E;
    push(1, 8'h81);
    push(3, 8'h7E);
    g0  = grants_seen;
    f0  = frames_done;
    req = 4'b1010;
    wait_grants(g0 + 1, "t4_regrant1");
    req[1] = 1'b0;
    wait_grants(g0 + 2, "t4_grant3");
    req = 4'b0000;
    wait_frames(f0 + 2, "t4_frames");

    // 5: baud ticks paused for 200 clocks in the data phase.
    data[2] = 8'h3C;
    push(2, 8'h3C);
    g0  = grants_seen;
    f0  = frames_done;
    req = 4'b0100;
    wait_grants(g0 + 1, "t5_grant");
    req = 4'b0000;
    wait_tick_idx(4, "t5_data");
    tick_on = 1'b0;
    repeat (200) @(negedge clock);
    tick_on = 1'b1;
    wait_frames(f0 + 1, "t5_frame");

    // 6: tick coincident with the arbitration edge must not start the frame.
    tick_on = 1'b0;
    repeat (20) @(negedge clock);
    data[0] = 8'hE7;
    push(0, 8'hE7);
    g0 = grants_seen;
    f0 = frames_done;
    @(negedge clock);
    force_tick = 1'b1;
    req        = 4'b0001;
    @(negedge clock);
    force_tick = 1'b0;
    req        = 4'b0000;
    repeat (10) @(negedge clock);
    tick_on = 1'b1;
    wait_grants(g0 + 1, "t6_grant");
    wait_frames(f0 + 1, "t6_frame");

    repeat (5) @(negedge clock);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
